peak_event_arbiter: RTL and testbench
=====================================

# peak_event_arbiter

Collects peak and valley events from the four-channel peak/valley detector and funnels them into one valid/ready event stream for the downstream recorder. Eight event sources are handled: peak and valley for channels 0–3. Each source has a one-deep holding slot. A round-robin scheduler drains the slots into a single output register, and overruns are flagged per source.

## Interface
- DATAWIDTH, 16, width of event values.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- arb_en  input  1  when 0, incoming event pulses are ignored (not captured, not counted); output still drains.
- clr  input  1  synchronous clear of all holding slots and ovf flags.
- PData0..PData3  input  DATAWIDTH each  peak values, sampled when matching _en is high.
- PData0_en..PData3_en  input  1 each  single-cycle peak strobes.
- VData0..VData3  input  DATAWIDTH each  valley values.
- VData0_en..VData3_en  input  1 each  single-cycle valley strobes.
- evt_data  output  DATAWIDTH  granted event value.
- evt_ch  output  2  channel of granted event.
- evt_valley  output  1  0 = peak, 1 = valley.
- evt_valid  output  1  output register holds an event.
- evt_ready  input  1  downstream accepts when evt_valid & evt_ready.
- ovf  output  8  sticky per-source overrun flags; bit s = 2*ch + valley.
- drop_cnt  output  16  total overrun count (see Configuration).

## Operation
- Source index s = 2*ch + valley: 0 = ch0 peak, 1 = ch0 valley, …, 7 = ch3 valley.
- Holding slot per source: pend[s] plus a DATAWIDTH-bit value.
- Capture: an _en pulse with arb_en = 1 writes the value and sets pend[s].
- Overrun: if pend[s] is already 1 and not being granted this cycle, the new value overwrites the slot, ovf[s] is set, and drop_cnt increments.
- Grant and capture on the same source in the same cycle: the new value is stored and pend stays 1. This is not an overrun.
- Output FSM, two states:
  - IDLE (evt_valid = 0): if any pend is set, load the winner into the output register and go to HOLD.
  - HOLD (evt_valid = 1): on evt_ready, either load the next winner (stay in HOLD) or go to IDLE if none is pending. Without evt_ready, hold all outputs stable.
- Load occurs when the FSM is in IDLE, or in HOLD with evt_ready = 1.
- On load, the winner's pend is cleared.
- Round robin: pointer ptr (3 bits, reset 0). The winner is the first pending source searching ptr, ptr+1, … mod 8. After a grant of s, ptr = (s+1) mod 8. ptr is unchanged when there is no grant.
- clr:
  - Clears all pend and ovf. Overrides any capture in the same cycle; that event is discarded and not counted.
  - Does not touch the output register, evt_valid or ptr; the handshake is preserved.
  - A pending load in the same cycle still completes, using pre-clr pend.
- Values are unsigned and passed through unmodified.

## Timing
- Reset values: evt_valid = 0, evt_data = 0, evt_ch = 0, evt_valley = 0, ovf = 0, drop_cnt = 0, all pend = 0, ptr = 0, FSM = IDLE.
- Reset mid-transfer abandons the event; there is no partial output.
- Latency: strobe sampled at edge E sets pend after E. With an idle output, evt_valid is high after edge E+1, a 2-cycle strobe-to-valid latency.
- Throughput: one event per cycle while evt_ready = 1 and sources are pending.
- evt_data, evt_ch and evt_valley are stable while evt_valid & !evt_ready.
- Worst-case service for any pending source is 8 grants.
- drop_cnt saturates at 16'hFFFF and never wraps.
- The arb_en change takes effect on strobes sampled in the same edge.

## Configuration
- PEAK_ARB_DROP_CNT_EN defined: the 16-bit saturating drop_cnt counter is implemented, cleared by rst only (not by clr).
- Undefined: drop_cnt is tied to 0 and no counter logic exists.
- ovf is present in both builds.

## Test plan
- Single event: PData2 = 16'h1234, PData2_en pulse, evt_ready = 1 → after 2 edges, evt_valid = 1, evt_data = 16'h1234, evt_ch = 2, evt_valley = 0, for one cycle.
- Round robin: all eight strobes in one cycle (values 16'h0010 + s), evt_ready = 1 → eight consecutive outputs in s order 0..7. A repeat burst after a grant of s = 3 starts at s = 4.
- Backpressure: hold evt_ready = 0 for 5 cycles with VData1 = 16'h00AA pending → outputs are stable at ch 1, valley, 16'h00AA. Release yields exactly one transfer.
- Overrun: two PData0_en pulses (16'h0001, then 16'h0002) while evt_ready = 0 and the output is held by another source → slot keeps 16'h0002, ovf[0] = 1, drop_cnt = 1 (0 without macro).
- clr collision: clr = 1 in the same cycle as a VData3_en pulse → no event emitted, ovf = 0, drop_cnt unchanged, the current output transfer is still completed.
- Async reset mid-HOLD: rst low with evt_valid = 1 → evt_valid = 0 immediately; after release, no stale event appears.

Source files
------------

// File: rtl/peak_event_arbiter.sv
// -----------------------------------------------------------------------------
// peak_event_arbiter
//
// Funnels peak/valley events from a four-channel peak/valley detector into a
// single valid/ready event stream. Eight sources (s = 2*ch + valley) each own
// a one-deep holding slot. A round-robin scheduler drains the slots into one
// output register. Per-source overruns are flagged in sticky ovf bits.
//
// Optional feature:
//   PEAK_ARB_DROP_CNT_EN  defined -> 16-bit saturating overrun counter on
//                         drop_cnt, cleared by rst only.
//                         undefined -> drop_cnt tied to zero.
//
// Handshake: evt_valid/evt_ready follow strict valid/ready semantics. An event
// transfers on a rising clk edge where evt_valid & evt_ready. Once evt_valid is
// high it stays high, and evt_data/evt_ch/evt_valley stay stable, until that
// transfer happens. evt_valid never depends combinationally on evt_ready.
//
// Ports:
//   clk                     system clock, rising edge
//   rst                     asynchronous active-low reset
//   arb_en                  gates capture of incoming strobes
//   clr                     synchronous clear of holding slots and ovf
//   PData0..3 / PData0..3_en  peak values and single-cycle strobes
//   VData0..3 / VData0..3_en  valley values and single-cycle strobes
//   evt_data/evt_ch/evt_valley/evt_valid  output event register
//   evt_ready               downstream accept
//   ovf                     sticky per-source overrun flags
//   drop_cnt                total overrun count (zero when feature disabled)
//   state_dbg               output FSM state (0 = IDLE, 1 = HOLD)
// -----------------------------------------------------------------------------
module peak_event_arbiter #(
   parameter int DATAWIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 arb_en,
   input  logic                 clr,
   input  logic [DATAWIDTH-1:0] PData0,
   input  logic [DATAWIDTH-1:0] PData1,
   input  logic [DATAWIDTH-1:0] PData2,
   input  logic [DATAWIDTH-1:0] PData3,
   input  logic                 PData0_en,
   input  logic                 PData1_en,
   input  logic                 PData2_en,
   input  logic                 PData3_en,
   input  logic [DATAWIDTH-1:0] VData0,
   input  logic [DATAWIDTH-1:0] VData1,
   input  logic [DATAWIDTH-1:0] VData2,
   input  logic [DATAWIDTH-1:0] VData3,
   input  logic                 VData0_en,
   input  logic                 VData1_en,
   input  logic                 VData2_en,
   input  logic                 VData3_en,
   output logic [DATAWIDTH-1:0] evt_data,
   output logic [1:0]           evt_ch,
   output logic                 evt_valley,
   output logic                 evt_valid,
   input  logic                 evt_ready,
   output logic [7:0]           ovf,
   output logic [15:0]          drop_cnt,
   output logic                 state_dbg
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t               state;

   // Source-indexed views of the input ports (s = 2*ch + valley)
   logic [DATAWIDTH-1:0] src_data [8];
   logic [7:0]           src_en;

   // Holding slots
   logic [7:0]           pend;
   logic [DATAWIDTH-1:0] slot [8];

   // Scheduler
   logic [2:0]           ptr;
   logic [2:0]           win;
   logic                 any_pend;
   logic                 load;
   logic [7:0]           grant;
   logic [7:0]           capture;
   logic [7:0]           overrun;

   always_comb begin
      src_data[0] = PData0;
      src_data[1] = VData0;
      src_data[2] = PData1;
      src_data[3] = VData1;
      src_data[4] = PData2;
      src_data[5] = VData2;
      src_data[6] = PData3;
      src_data[7] = VData3;
      src_en = {VData3_en, PData3_en, VData2_en, PData2_en,
                VData1_en, PData1_en, VData0_en, PData0_en};
   end

   // First pending source searching from ptr upward, wrapping mod 8.
   // The 3-bit index sum wraps naturally.
   always_comb begin
      win      = ptr;
      any_pend = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (!any_pend && pend[ptr + 3'(i)]) begin
            win      = ptr + 3'(i);
            any_pend = 1'b1;
         end
      end
   end

   // The output register is free when empty or when its event leaves this edge
   assign load    = any_pend && ((state == ST_IDLE) || evt_ready);
   assign grant   = load ? (8'b1 << win) : 8'b0;
   assign capture = src_en & {8{arb_en}};
   // A capture into a slot that is simultaneously granted is a refill, not
   // an overrun. clr discards the capture, so nothing is counted either.
   assign overrun = capture & pend & ~grant & {8{~clr}};

   // Holding slots and sticky overrun flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend <= '0;
         ovf  <= '0;
         for (int s = 0; s < 8; s++) begin
            slot[s] <= '0;
         end
      end else if (clr) begin
         pend <= '0;
         ovf  <= '0;
      end else begin
         for (int s = 0; s < 8; s++) begin
            if (capture[s]) begin
               pend[s] <= 1'b1;
               slot[s] <= src_data[s];
            end else if (grant[s]) begin
               pend[s] <= 1'b0;
            end
         end
         ovf <= ovf | overrun;
      end
   end

   // Output FSM and output register. clr deliberately does not reach here:
   // a load on the clr edge still completes using the pre-clr slot contents.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         evt_valid  <= 1'b0;
         evt_data   <= '0;
         evt_ch     <= '0;
         evt_valley <= 1'b0;
         ptr        <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (load) begin
                  evt_data   <= slot[win];
                  evt_ch     <= win[2:1];
                  evt_valley <= win[0];
                  ptr        <= win + 3'd1;
                  evt_valid  <= 1'b1;
                  state      <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (load) begin
                  evt_data   <= slot[win];
                  evt_ch     <= win[2:1];
                  evt_valley <= win[0];
                  ptr        <= win + 3'd1;
               end else if (evt_ready) begin
                  evt_valid  <= 1'b0;
                  state      <= ST_IDLE;
               end
            end
            default: begin
               evt_valid <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign state_dbg = state;

`ifdef PEAK_ARB_DROP_CNT_EN
   // Several sources can overrun on the same edge, so add the whole count
   logic [3:0]  ovr_num;
   logic [16:0] drop_sum;

   always_comb begin
      ovr_num = '0;
      for (int s = 0; s < 8; s++) begin
         ovr_num = ovr_num + {3'b000, overrun[s]};
      end
   end

   assign drop_sum = {1'b0, drop_cnt} + {13'b0, ovr_num};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_cnt <= '0;
      end else begin
         drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
   end
`else
   assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_peak_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_peak_event_arbiter
//
// Self-checking bench for peak_event_arbiter. A cycle-level reference model
// of the slots, the round-robin order and the output register pushes every
// expected event into exp_q when it is granted. A separate monitor pops and
// compares on each observed transfer. ovf and drop_cnt are checked against the
// model. Directed scenarios are followed by a randomized phase and by a
// drop_cnt saturation run.
// -----------------------------------------------------------------------------
module tb_peak_event_arbiter;

   localparam int DW = 16;

   // ---------------- clock / reset ----------------
   logic clk    = 1'b0;
   logic rst    = 1'b0;
   logic arb_en = 1'b0;
   logic clr    = 1'b0;
   logic rdy    = 1'b0;

   always #5 clk = ~clk;

   logic [DW-1:0] pd [4];
   logic [DW-1:0] vd [4];
   logic          pd_en [4];
   logic          vd_en [4];

   logic [DW-1:0] evt_data;
   logic [1:0]    evt_ch;
   logic          evt_valley;
   logic          evt_valid;
   logic [7:0]    ovf;
   logic [15:0]   drop_cnt;
   logic          state_dbg;

   peak_event_arbiter #(.DATAWIDTH(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .arb_en     (arb_en),
      .clr        (clr),
      .PData0     (pd[0]),
      .PData1     (pd[1]),
      .PData2     (pd[2]),
      .PData3     (pd[3]),
      .PData0_en  (pd_en[0]),
      .PData1_en  (pd_en[1]),
      .PData2_en  (pd_en[2]),
      .PData3_en  (pd_en[3]),
      .VData0     (vd[0]),
      .VData1     (vd[1]),
      .VData2     (vd[2]),
      .VData3     (vd[3]),
      .VData0_en  (vd_en[0]),
      .VData1_en  (vd_en[1]),
      .VData2_en  (vd_en[2]),
      .VData3_en  (vd_en[3]),
      .evt_data   (evt_data),
      .evt_ch     (evt_ch),
      .evt_valley (evt_valley),
      .evt_valid  (evt_valid),
      .evt_ready  (rdy),
      .ovf        (ovf),
      .drop_cnt   (drop_cnt),
      .state_dbg  (state_dbg)
   );

   // ---------------- scoreboard state ----------------
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [18:0] exp_q [$];   // {ch, valley, data}

   // Reference model
   bit          m_pend [8];
   logic [15:0] m_val [8];
   int          m_ptr;
   bit          m_full;
   logic [7:0]  m_ovf;
   int          m_drop;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] exp_drop();
`ifdef PEAK_ARB_DROP_CNT_EN
      return m_drop[15:0];
`else
      return 16'h0000;
`endif
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 8; s++) begin
         m_pend[s] = 1'b0;
         m_val[s]  = '0;
      end
      m_ptr  = 0;
      m_full = 1'b0;
      m_ovf  = '0;
      m_drop = 0;
      exp_q.delete();
   endtask

   // Applies one rising edge to the model using the inputs present at that edge
   task automatic model_step();
      int          win;
      bit          load;
      bit          en;
      logic [15:0] d;
      int          ch;
      win = -1;
      for (int i = 0; i < 8; i++) begin
         if (win < 0 && m_pend[(m_ptr + i) % 8]) win = (m_ptr + i) % 8;
      end
      if (m_full && rdy) m_full = 1'b0;
      load = (win >= 0) && !m_full;
      if (load) begin
         exp_q.push_back({2'(win / 2), 1'(win % 2), m_val[win]});
         m_full = 1'b1;
         m_ptr  = (win + 1) % 8;
      end
      for (int s = 0; s < 8; s++) begin
         ch = s / 2;
         en = (s % 2) ? vd_en[ch] : pd_en[ch];
         d  = (s % 2) ? vd[ch] : pd[ch];
         if (!clr && arb_en && en) begin
            if (m_pend[s] && !(load && win == s)) begin
               m_ovf[s] = 1'b1;
               if (m_drop < 65535) m_drop++;
            end
            m_pend[s] = 1'b1;
            m_val[s]  = d;
         end else if (load && win == s) begin
            m_pend[s] = 1'b0;
         end
      end
      if (clr) begin
         for (int s = 0; s < 8; s++) m_pend[s] = 1'b0;
         m_ovf = '0;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_strobes();
      for (int c = 0; c < 4; c++) begin
         pd_en[c] = 1'b0;
         vd_en[c] = 1'b0;
      end
      clr = 1'b0;
   endtask

   // One clock: model follows the edge, then single-cycle pulses drop
   task automatic tick();
      @(posedge clk);
      if (rst) model_step();
      #1;
      clear_strobes();
   endtask

   task automatic strobe(input int s, input logic [15:0] v);
      if (s % 2) begin
         vd[s / 2]    = v;
         vd_en[s / 2] = 1'b1;
      end else begin
         pd[s / 2]    = v;
         pd_en[s / 2] = 1'b1;
      end
   endtask

   task automatic drain(input int n);
      rdy = 1'b1;
      repeat (n) tick();
   endtask

   // ---------------- monitor ----------------
   bit          prev_stall = 1'b0;
   logic [18:0] prev_out;

   always @(negedge clk) begin
      logic [18:0] got;
      got = {evt_ch, evt_valley, evt_data};
      if (rst) begin
         if (prev_stall && evt_valid) chk("stable_under_stall", 32'(got), 32'(prev_out));
         if (evt_valid && rdy) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_event: got %h expected none at %0t", got, $time);
            end else begin
               chk("evt_stream", 32'(got), 32'(exp_q.pop_front()));
            end
         end
         prev_stall = evt_valid && !rdy;
         prev_out   = got;
      end else begin
         prev_stall = 1'b0;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      for (int c = 0; c < 4; c++) begin
         pd[c] = '0;
         vd[c] = '0;
      end
      clear_strobes();
      model_reset();

      // Reset state
      repeat (2) tick();
      chk("rst_valid",  32'(evt_valid),  32'h0);
      chk("rst_data",   32'(evt_data),   32'h0);
      chk("rst_ch",     32'(evt_ch),     32'h0);
      chk("rst_valley", 32'(evt_valley), 32'h0);
      chk("rst_ovf",    32'(ovf),        32'h0);
      chk("rst_drop",   32'(drop_cnt),   32'h0);
      rst    = 1'b1;
      arb_en = 1'b1;
      rdy    = 1'b1;
      tick();

      // Round robin: all eight sources at once, order 0..7 from ptr = 0
      for (int s = 0; s < 8; s++) strobe(s, 16'h0010 + 16'(s));
      tick();
      drain(12);
      // Grant s = 3 alone, then a burst must start at s = 4
      strobe(3, 16'h0333);
      tick();
      drain(4);
      for (int s = 0; s < 8; s++) strobe(s, 16'h0020 + 16'(s));
      tick();
      drain(12);

      // Single event latency: valid after two edges, for one cycle
      strobe(4, 16'h1234);
      tick();
      tick();
      chk("single_valid",  32'(evt_valid),  32'h1);
      chk("single_data",   32'(evt_data),   32'h1234);
      chk("single_ch",     32'(evt_ch),     32'h2);
      chk("single_valley", 32'(evt_valley), 32'h0);
      tick();
      chk("single_one_cycle", 32'(evt_valid), 32'h0);

      // Backpressure with VData1 pending
      rdy = 1'b0;
      strobe(3, 16'h00AA);
      tick();
      tick();
      repeat (5) begin
         chk("bp_valid",  32'(evt_valid),  32'h1);
         chk("bp_data",   32'(evt_data),   32'h00AA);
         chk("bp_ch",     32'(evt_ch),     32'h1);
         chk("bp_valley", 32'(evt_valley), 32'h1);
         tick();
      end
      rdy = 1'b1;
      tick();
      chk("bp_one_transfer", 32'(evt_valid), 32'h0);
      tick();

      // Overrun on PData0 while the output is held by PData1
      rdy = 1'b0;
      strobe(2, 16'h0BBB);
      tick();
      tick();
      strobe(0, 16'h0001);
      tick();
      strobe(0, 16'h0002);
      tick();
      chk("ovr_ovf",  32'(ovf),      32'h01);
      chk("ovr_drop", 32'(drop_cnt), 32'(exp_drop()));
      drain(6);

      // clr collides with a VData3 strobe while an output is held
      rdy = 1'b0;
      strobe(5, 16'h00C5);
      tick();
      tick();
      strobe(0, 16'h0077);
      tick();
      clr = 1'b1;
      strobe(7, 16'h3333);
      tick();
      chk("clr_ovf",   32'(ovf),       32'h0);
      chk("clr_drop",  32'(drop_cnt),  32'(exp_drop()));
      chk("clr_held",  32'(evt_valid), 32'h1);
      drain(2);
      chk("clr_no_evt", 32'(evt_valid), 32'h0);
      drain(3);

      // Randomized traffic
      repeat (1500) begin
         arb_en = ($urandom_range(0, 9) != 0);
         rdy    = ($urandom_range(0, 3) != 0);
         clr    = ($urandom_range(0, 60) == 0);
         for (int s = 0; s < 8; s++) begin
            if ($urandom_range(0, 4) == 0) strobe(s, 16'($urandom));
         end
         tick();
         chk("rand_ovf",  32'(ovf),      32'(m_ovf));
         chk("rand_drop", 32'(drop_cnt), 32'(exp_drop()));
      end
      arb_en = 1'b1;
      drain(20);

      // Saturation: every source overruns every cycle with the output stalled
      rdy = 1'b0;
      repeat (8300) begin
         for (int s = 0; s < 8; s++) strobe(s, 16'($urandom));
         tick();
      end
      chk("sat_ovf",  32'(ovf),      32'hFF);
      chk("sat_drop", 32'(drop_cnt), 32'(exp_drop()));
      clr = 1'b1;
      tick();
      drain(4);
      chk("sat_kept", 32'(drop_cnt), 32'(exp_drop()));

      // Async reset while an event is held
      rdy = 1'b0;
      strobe(6, 16'h0666);
      tick();
      strobe(1, 16'h0111);
      tick();
      chk("hold_before_rst", 32'(evt_valid), 32'h1);
      rst = 1'b0;
      #1;
      chk("rst_async_valid", 32'(evt_valid), 32'h0);
      chk("rst_async_drop",  32'(drop_cnt),  32'h0);
      model_reset();
      repeat (2) tick();
      rst = 1'b1;
      rdy = 1'b1;
      repeat (6) tick();
      chk("no_stale_evt", 32'(evt_valid), 32'h0);

      // Final drain and leftover check
      drain(10);
      chk("exp_q_empty", 32'(exp_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
